pipe_mem_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch (IF) and data access (MEM stage).

---
 rtl/pipe_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_pipe_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one single-port memory between instruction fetch and the MEM stage; ARB_PERF_CNT_EN adds stall counters.
// Latency: grant -> *_valid is one cycle per BUSY cycle plus one (min 2); successive grants are at least 3 cycles apart.
// Backpressure: requesters hold req until their valid pulse; stall flags any waiting request; m_req held until m_ready or timeout.
module pipe_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        stall,
    output logic        err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] if_stall_cnt,
    output logic [31:0] d_stall_cnt
`endif
);

    localparam int              SC_W      = $clog2(STARVE_MAX + 2);
    localparam logic [SC_W-1:0] SC_MAX    = SC_W'(STARVE_MAX);
    localparam logic [7:0]      WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    state_t          state;
    state_t          state_nxt;
    logic [SC_W-1:0] starve_cnt;
    logic [7:0]      wait_cnt;
    mreq_t           m_cmd;
    mreq_t           cmd_nxt;
    logic            busy;
    logic            done;
    logic            abort;
    logic            if_wait;
    logic            d_wait;

    assign busy  = (state == BUSY_I) || (state == BUSY_D);
    assign done  = busy && m_ready;
    assign abort = busy && !m_ready && (wait_cnt == WAIT_LAST);

    assign m_we    = m_cmd.we;
    assign m_addr  = m_cmd.addr;
    assign m_wdata = m_cmd.wdata;

    // Fetches never write, so their command carries zero write data.
    assign cmd_nxt = '{we:    d_gnt & d_we,
                       addr:  d_gnt ? d_addr : if_addr,
                       wdata: d_gnt ? d_wdata : 32'h0};

    assign if_wait = if_req && !if_gnt && !if_valid;
    assign d_wait  = d_req && !d_gnt && !d_valid;
    assign stall   = if_wait || d_wait;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        case (state)
            IDLE: begin
                // The cycle a valid pulse leaves is a dead cycle for arbitration.
                if (!if_valid && !d_valid) begin
                    if (d_req && (starve_cnt < SC_MAX)) begin
                        d_gnt     = 1'b1;
                        state_nxt = BUSY_D;
                    end else if (if_req) begin
                        if_gnt    = 1'b1;
                        state_nxt = BUSY_I;
                    end else if (d_req) begin
                        d_gnt     = 1'b1;
                        state_nxt = BUSY_D;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (done || abort) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_req    <= 1'b0;
            m_cmd    <= '0;
            wait_cnt <= 8'h0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
            if_rdata <= 32'h0;
            d_rdata  <= 32'h0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
            if (if_gnt || d_gnt) begin
                m_req    <= 1'b1;
                m_cmd    <= cmd_nxt;
                wait_cnt <= 8'h0;
            end else if (done || abort) begin
                m_req <= 1'b0;
                err   <= abort;
                if (state == BUSY_I) begin
                    if_valid <= 1'b1;
                    if_rdata <= done ? m_rdata : 32'h0;
                end else begin
                    d_valid <= 1'b1;
                    d_rdata <= (done && !m_cmd.we) ? m_rdata : 32'h0;
                end
            end else if (busy && (wait_cnt != 8'hFF)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Counts data grants that overtook a waiting fetch; at the limit the fetch wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && if_req && (starve_cnt < SC_MAX)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_stall_cnt <= 32'h0;
            d_stall_cnt  <= 32'h0;
        end else begin
            if (if_wait) begin
                if_stall_cnt <= if_stall_cnt + 32'd1;
            end
            if (d_wait) begin
                d_stall_cnt <= d_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Bench for pipe_mem_arbiter: directed scenarios, then a random phase checked against a
// transaction-level arbitration/memory model; the bench itself plays the memory.
module tb_pipe_mem_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        stall;
    logic        err;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt;
    logic [31:0] d_stall_cnt;
`endif

    int          total = 0;
    int          bad = 0;
    int          mem_lat = 0;
    int          busy_idx = 0;
    logic [31:0] mem [256];
    int          model_if_wait = 0;
    int          model_d_wait = 0;
    string       grant_log;

    pipe_mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .stall(stall), .err(err)
`ifdef ARB_PERF_CNT_EN
        , .if_stall_cnt(if_stall_cnt), .d_stall_cnt(d_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge and play the memory for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (m_req) begin
            if (mem_lat >= 0 && busy_idx == mem_lat) begin
                m_ready = 1'b1;
                if (m_we) begin
                    mem[m_addr[7:0]] = m_wdata;
                    m_rdata = $urandom;
                end else begin
                    m_rdata = mem[m_addr[7:0]];
                end
            end else begin
                m_ready = 1'b0;
                m_rdata = $urandom;
            end
            busy_idx++;
        end else begin
            m_ready  = 1'b0;
            m_rdata  = $urandom;
            busy_idx = 0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b1;
        busy_idx = 0;
    endtask

    // Transaction-level model: who wins each arbitration, when the access finishes, what data returns.
    task automatic run(input int ncyc, input bit contend);
        int          owner = 0;
        int          grant_c = 0;
        int          done_c = 0;
        int          free_c = 0;
        int          sc = 0;
        int          lat;
        int          r;
        bit          vi_prev = 0;
        bit          vd_prev = 0;
        bit          egi, egd, evi, evd, emreq;
        logic [31:0] exp_rd = 0;
        logic [31:0] exp_addr = 0;
        logic [31:0] exp_wdata = 0;
        logic        exp_we = 0;
        bit          exp_err = 0;
        grant_log     = "";
        model_if_wait = 0;
        model_d_wait  = 0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (vi_prev) if_req = 1'b0;
            if (!if_req && (contend || $urandom_range(0, 1) == 1)) begin
                if_req  = 1'b1;
                if_addr = $urandom;
            end
            if (vd_prev) d_req = 1'b0;
            if (!d_req && (contend || $urandom_range(0, 1) == 1)) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            evi   = (owner == 1) && (c == done_c);
            evd   = (owner == 2) && (c == done_c);
            emreq = (owner != 0) && (c > grant_c) && (c < done_c);
            egi   = 1'b0;
            egd   = 1'b0;
            if (owner == 0 && c >= free_c) begin
                if (d_req && sc < STARVE_MAX) egd = 1'b1;
                else if (if_req)              egi = 1'b1;
                else if (d_req)               egd = 1'b1;
            end
            if (if_req && !egi && !evi) model_if_wait++;
            if (d_req && !egd && !evd)  model_d_wait++;
            settle();
            chk("rnd if_gnt", if_gnt, egi);
            chk("rnd d_gnt", d_gnt, egd);
            chk("rnd if_valid", if_valid, evi);
            chk("rnd d_valid", d_valid, evd);
            chk("rnd m_req", m_req, emreq);
            chk("rnd stall", stall, (if_req && !egi && !evi) || (d_req && !egd && !evd));
            if (emreq) begin
                chk("rnd m_addr", m_addr, exp_addr);
                chk("rnd m_we", m_we, exp_we);
                chk("rnd m_wdata", m_wdata, exp_wdata);
            end
            if (evi || evd) begin
                chk("rnd err", err, exp_err);
                chk("rnd rdata", evi ? if_rdata : d_rdata, exp_rd);
                owner  = 0;
                free_c = c + 1;
            end
            if (egi || egd) begin
                r       = int'($urandom_range(0, 15));
                lat     = contend ? 0 : ((r == 15) ? -1 : r % 4);
                mem_lat = lat;
                grant_c = c;
                done_c  = c + ((lat < 0) ? TIMEOUT : lat + 1) + 1;
                exp_err = (lat < 0);
                if (egd) begin
                    if (if_req && sc < STARVE_MAX) sc++;
                    owner     = 2;
                    exp_addr  = d_addr;
                    exp_we    = d_we;
                    exp_wdata = d_wdata;
                    exp_rd    = (lat < 0 || d_we) ? 32'h0 : mem[d_addr[7:0]];
                    grant_log = {grant_log, "D"};
                end else begin
                    sc        = 0;
                    owner     = 1;
                    exp_addr  = if_addr;
                    exp_we    = 1'b0;
                    exp_wdata = 32'h0;
                    exp_rd    = (lat < 0) ? 32'h0 : mem[if_addr[7:0]];
                    grant_log = {grant_log, "I"};
                end
            end
            vi_prev = evi;
            vd_prev = evd;
        end
    endtask

    initial begin
        int n_hi;
        bit got;
        if_addr = 32'h0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        m_rdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h00500093;

        // reset state
        do_reset();
        settle();
        chk("rst m_req", m_req, 0);
        chk("rst m_we", m_we, 0);
        chk("rst m_addr", m_addr, 0);
        chk("rst m_wdata", m_wdata, 0);
        chk("rst if_valid", if_valid, 0);
        chk("rst d_valid", d_valid, 0);
        chk("rst if_rdata", if_rdata, 0);
        chk("rst d_rdata", d_rdata, 0);
        chk("rst err", err, 0);
        chk("rst stall", stall, 0);
`ifdef ARB_PERF_CNT_EN
        chk("rst if_stall_cnt", if_stall_cnt, 0);
        chk("rst d_stall_cnt", d_stall_cnt, 0);
`endif

        // IF only, memory ready in the first BUSY cycle
        mem_lat = 0;
        tick(); if_req = 1'b1; if_addr = 32'h100;
        settle();
        chk("t1 if_gnt", if_gnt, 1);
        chk("t1 m_req c0", m_req, 0);
        chk("t1 stall c0", stall, 0);
        tick(); settle();
        chk("t1 m_req c1", m_req, 1);
        chk("t1 m_addr", m_addr, 32'h100);
        chk("t1 m_we", m_we, 0);
        chk("t1 stall c1", stall, 1);
        tick(); settle();
        chk("t1 if_valid", if_valid, 1);
        chk("t1 if_rdata", if_rdata, 32'h00500093);
        chk("t1 m_req c2", m_req, 0);
        chk("t1 no regrant", if_gnt, 0);
        chk("t1 err", err, 0);
        tick(); if_req = 1'b0;

        // store with three wait states
        mem_lat = 3;
        tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        settle();
        chk("t2 d_gnt", d_gnt, 1);
        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            chk("t2 m_req", m_req, 1);
            chk("t2 m_we", m_we, 1);
            chk("t2 m_wdata", m_wdata, 32'hDEADBEEF);
            chk("t2 stall", stall, 1);
        end
        tick(); settle();
        chk("t2 d_valid", d_valid, 1);
        chk("t2 d_rdata", d_rdata, 0);
        chk("t2 m_req off", m_req, 0);
        tick(); d_req = 1'b0; d_we = 1'b0;

        // timeout on a load
        mem_lat = -1;
        tick(); d_req = 1'b1; d_addr = 32'h44;
        settle();
        chk("t4 d_gnt", d_gnt, 1);
        n_hi = 0;
        got  = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            tick(); settle();
            if (m_req) n_hi++;
            if (d_valid) begin
                got = 1'b1;
                chk("t4 err", err, 1);
                chk("t4 d_rdata", d_rdata, 0);
            end
        end
        chk("t4 valid seen", got, 1);
        chk("t4 m_req cycles", n_hi, TIMEOUT);
        mem_lat = 0;
        tick(); settle();
        chk("t4 idle regrant", d_gnt, 1);
        chk("t4 err pulse", err, 0);
        tick(); settle();
        tick(); settle();
        chk("t4 d_valid 2", d_valid, 1);
        chk("t4 d_rdata 2", d_rdata, mem[8'h44]);
        tick(); d_req = 1'b0;

        // reset in the middle of a data access
        mem_lat = -1;
        tick(); d_req = 1'b1; d_addr = 32'h80;
        settle();
        chk("t5 d_gnt", d_gnt, 1);
        tick(); settle();
        chk("t5 m_req busy", m_req, 1);
        tick();
        reset = 1'b0; d_req = 1'b0; if_req = 1'b1; if_addr = 32'h200;
        #1;
        chk("t5 m_req async", m_req, 0);
        @(posedge clk); #1;
        chk("t5 no d_valid rst", d_valid, 0);
        reset    = 1'b1;
        busy_idx = 0;
        mem_lat  = 0;
        settle();
        chk("t5 if_gnt first", if_gnt, 1);
        chk("t5 d_valid", d_valid, 0);
        tick(); settle();
        chk("t5 m_addr", m_addr, 32'h200);
        tick(); settle();
        chk("t5 if_valid", if_valid, 1);
        chk("t5 if_rdata", if_rdata, mem[8'h00]);
        chk("t5 no d_valid", d_valid, 0);
        tick(); if_req = 1'b0;

        // contention: both requesters held
        do_reset();
        run(20, 1'b1);
        total++;
        assert (grant_log.substr(0, 5) == "DDDDID") else begin
            bad++;
            $error("FAIL t3 grant order: got %s want DDDDID", grant_log);
        end
        chk("t3 grant count", grant_log.len(), 7);
`ifdef ARB_PERF_CNT_EN
        tick(); settle();
        chk("t6 if_stall_cnt", if_stall_cnt, model_if_wait);
        chk("t6 d_stall_cnt", d_stall_cnt, model_d_wait);
`endif

        // random traffic with random wait states and occasional timeouts
        do_reset();
        run(600, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
